// File: rtl/pedda_rsp_pkt_tx.sv
// PEDDA target-side response packet transmitter: frames one request as SOP, header, payload,
// CRC-16-CCITT and EOP on the 8-bit K-flagged link. Optional macro: PEDDA_RSP_CRC_ERR_INJECT_EN.
module pedda_rsp_pkt_tx #(
  parameter int MAX_PAYLOAD_BYTES = 16,
  parameter int IDLE_GAP          = 2
) (
  input  logic                           ieee_1149_10_clk,
  input  logic                           reset,
  input  logic                           rsp_valid,
  output logic                           rsp_ready,
  input  logic [7:0]                     rsp_cmd,
  input  logic [15:0]                    rsp_target_id,
  input  logic [7:0]                     rsp_len,
  input  logic [8*MAX_PAYLOAD_BYTES-1:0] rsp_payload,
`ifdef PEDDA_RSP_CRC_ERR_INJECT_EN
  input  logic                           rsp_crc_err,
`endif
  output logic [7:0]                     ieee_1149_10_parallel_out,
  output logic                           tx_k_out,
  output logic                           tx_busy,
  output logic                           tx_done,
  output logic                           len_clamped
);

  localparam int         PW       = 8 * MAX_PAYLOAD_BYTES;
  localparam logic [7:0] CH_IDLE  = 8'hBC;
  localparam logic [7:0] CH_SOP   = 8'hFB;
  localparam logic [7:0] CH_EOP   = 8'hFD;
  localparam logic [7:0] MAX_LEN  = 8'(MAX_PAYLOAD_BYTES);
  localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_HDR,
    S_PAYLOAD,
    S_CRC_H,
    S_CRC_L,
    S_EOP,
    S_GAP
  } state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [7:0]    cmd_q;
  logic [15:0]   id_q;
  logic [7:0]    len_q;
  logic [PW-1:0] payload_q;
  logic [15:0]   crc_q;
  logic [7:0]    hdr_byte;
  logic [7:0]    pay_byte;
  logic [7:0]    crc_l_byte;
  logic          accept;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] sat_len(input logic [7:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  assign accept   = (state == S_IDLE) && rsp_valid && rsp_ready;
  assign pay_byte = payload_q[PW-1 -: 8];

  always_comb begin
    hdr_byte = len_q;
    case (cnt[1:0])
      2'd0:    hdr_byte = cmd_q;
      2'd1:    hdr_byte = id_q[15:8];
      2'd2:    hdr_byte = id_q[7:0];
      default: hdr_byte = len_q;
    endcase
  end

`ifdef PEDDA_RSP_CRC_ERR_INJECT_EN
  logic crc_err_q;

  always_ff @(posedge ieee_1149_10_clk) begin
    if (accept) crc_err_q <= rsp_crc_err;
  end

  // Only the transmitted low CRC byte is corrupted; crc_q itself stays correct.
  assign crc_l_byte = crc_q[7:0] ^ {7'b0, crc_err_q};
`else
  assign crc_l_byte = crc_q[7:0];
`endif

  // Request latch and running CRC, advanced one byte per transmitted header/payload byte
  always_ff @(posedge ieee_1149_10_clk) begin
    if (accept) begin
      cmd_q     <= rsp_cmd;
      id_q      <= rsp_target_id;
      len_q     <= sat_len(rsp_len);
      payload_q <= rsp_payload;
      crc_q     <= 16'hFFFF;
    end else if (state == S_HDR) begin
      crc_q <= crc16_byte(crc_q, hdr_byte);
    end else if (state == S_PAYLOAD) begin
      crc_q     <= crc16_byte(crc_q, pay_byte);
      payload_q <= payload_q << 8;
    end
  end

  // Framing FSM; every line output is registered from the current state
  always_ff @(posedge ieee_1149_10_clk) begin
    if (reset) begin
      state                     <= S_IDLE;
      cnt                       <= '0;
      rsp_ready                 <= 1'b0;
      ieee_1149_10_parallel_out <= CH_IDLE;
      tx_k_out                  <= 1'b1;
      tx_busy                   <= 1'b0;
      tx_done                   <= 1'b0;
      len_clamped               <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      len_clamped <= 1'b0;
      case (state)
        S_IDLE: begin
          ieee_1149_10_parallel_out <= CH_IDLE;
          tx_k_out                  <= 1'b1;
          tx_busy                   <= 1'b0;
          if (accept) begin
            state       <= S_SOP;
            rsp_ready   <= 1'b0;
            len_clamped <= (rsp_len > MAX_LEN);
          end else begin
            rsp_ready <= 1'b1;
          end
        end
        S_SOP: begin
          ieee_1149_10_parallel_out <= CH_SOP;
          tx_k_out                  <= 1'b1;
          tx_busy                   <= 1'b1;
          cnt                       <= '0;
          state                     <= S_HDR;
        end
        S_HDR: begin
          ieee_1149_10_parallel_out <= hdr_byte;
          tx_k_out                  <= 1'b0;
          if (cnt == 8'd3) begin
            cnt   <= '0;
            state <= (len_q == 8'd0) ? S_CRC_H : S_PAYLOAD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_PAYLOAD: begin
          ieee_1149_10_parallel_out <= pay_byte;
          tx_k_out                  <= 1'b0;
          if ({1'b0, cnt} + 9'd1 == {1'b0, len_q}) begin
            cnt   <= '0;
            state <= S_CRC_H;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CRC_H: begin
          ieee_1149_10_parallel_out <= crc_q[15:8];
          tx_k_out                  <= 1'b0;
          state                     <= S_CRC_L;
        end
        S_CRC_L: begin
          ieee_1149_10_parallel_out <= crc_l_byte;
          tx_k_out                  <= 1'b0;
          cnt                       <= '0;
          state                     <= S_EOP;
        end
        S_EOP: begin
          ieee_1149_10_parallel_out <= CH_EOP;
          tx_k_out                  <= 1'b1;
          if (cnt == 8'd3) begin
            tx_done <= 1'b1;
            cnt     <= '0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_GAP: begin
          ieee_1149_10_parallel_out <= CH_IDLE;
          tx_k_out                  <= 1'b1;
          tx_busy                   <= 1'b0;
          if (cnt == GAP_LAST) begin
            cnt       <= '0;
            state     <= S_IDLE;
            rsp_ready <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pedda_rsp_pkt_tx.sv
// Directed and randomized bench for pedda_rsp_pkt_tx with a frame-level reference model.
module tb_pedda_rsp_pkt_tx;

  localparam int MAXP = 16;
  localparam int GAP  = 2;
  localparam int PW   = 8 * MAXP;

  logic          clk = 1'b0;
  logic          reset;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_cmd;
  logic [15:0]   rsp_target_id;
  logic [7:0]    rsp_len;
  logic [PW-1:0] rsp_payload;
`ifdef PEDDA_RSP_CRC_ERR_INJECT_EN
  logic          rsp_crc_err;
`endif
  logic [7:0]    line_out;
  logic          tx_k_out;
  logic          tx_busy;
  logic          tx_done;
  logic          len_clamped;

  int n_total = 0;
  int n_pass  = 0;

  // Expected frame entries: {rsp_ready, tx_busy, tx_done, k, byte}
  logic [11:0] exp_q[$];
  logic [7:0]  lit [11] = '{8'hFB, 8'h81, 8'h00, 8'h01, 8'h00, 8'h1C, 8'h7D,
                            8'hFD, 8'hFD, 8'hFD, 8'hFD};

  pedda_rsp_pkt_tx #(.MAX_PAYLOAD_BYTES(MAXP), .IDLE_GAP(GAP)) dut (
    .ieee_1149_10_clk          (clk),
    .reset                     (reset),
    .rsp_valid                 (rsp_valid),
    .rsp_ready                 (rsp_ready),
    .rsp_cmd                   (rsp_cmd),
    .rsp_target_id             (rsp_target_id),
    .rsp_len                   (rsp_len),
    .rsp_payload               (rsp_payload),
`ifdef PEDDA_RSP_CRC_ERR_INJECT_EN
    .rsp_crc_err               (rsp_crc_err),
`endif
    .ieee_1149_10_parallel_out (line_out),
    .tx_k_out                  (tx_k_out),
    .tx_busy                   (tx_busy),
    .tx_done                   (tx_done),
    .len_clamped               (len_clamped)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] line_now();
    return {rsp_ready, tx_busy, tx_done, tx_k_out, line_out};
  endfunction

  function automatic logic [10:0] idle_now();
    return {tx_busy, tx_done, tx_k_out, line_out};
  endfunction

  // Reference frame from the framing rules, CRC computed bit-serially.
  task automatic build_frame(input logic [7:0] cmd, input logic [15:0] id, input logic [7:0] len_raw,
                             input logic [PW-1:0] pay, input bit err);
    int          n;
    logic [7:0]  body[$];
    logic [7:0]  b;
    logic [15:0] c;
    logic        fb;
    n = (int'(len_raw) > MAXP) ? MAXP : int'(len_raw);
    body.delete();
    body.push_back(cmd);
    body.push_back(id[15:8]);
    body.push_back(id[7:0]);
    body.push_back(8'(n));
    for (int i = 0; i < n; i++) body.push_back(pay[PW-1-8*i -: 8]);
    c = 16'hFFFF;
    foreach (body[i]) begin
      b = body[i];
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ b[j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    exp_q.delete();
    exp_q.push_back({4'b0101, 8'hFB});
    foreach (body[i]) exp_q.push_back({4'b0100, body[i]});
    exp_q.push_back({4'b0100, c[15:8]});
    exp_q.push_back({4'b0100, c[7:0] ^ {7'b0, err}});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b01, (i == 3), 1'b1, 8'hFD});
  endtask

  task automatic present(input logic [7:0] cmd, input logic [15:0] id, input logic [7:0] len,
                         input logic [PW-1:0] pay, input bit err);
    rsp_cmd       = cmd;
    rsp_target_id = id;
    rsp_len       = len;
    rsp_payload   = pay;
`ifdef PEDDA_RSP_CRC_ERR_INJECT_EN
    rsp_crc_err   = err;
`else
    if (err) $display("note: crc_err ignored in this build");
`endif
  endtask

  task automatic scramble();
    present(8'($urandom), 16'($urandom), 8'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 1'b0);
  endtask

  task automatic accept_wait(input string tag);
    int w;
    w = 0;
    while (rsp_ready !== 1'b1 && w < 64) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, 32'(rsp_ready), 32'd1);
    tick();
  endtask

  // Presents a request, accepts it, then scrambles inputs; returns with SOP on the line.
  task automatic send_start(input logic [7:0] cmd, input logic [15:0] id, input logic [7:0] len,
                            input logic [PW-1:0] pay, input bit err, input string tag);
    build_frame(cmd, id, len, pay, err);
    present(cmd, id, len, pay, err);
    rsp_valid = 1'b1;
    accept_wait(tag);
    check({tag, "_clamp"}, 32'(len_clamped), 32'(int'(len) > MAXP));
    rsp_valid = 1'b0;
    scramble();
    tick();
    check({tag, "_clamp_off"}, 32'(len_clamped), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      check($sformatf("%s_byte%0d", tag, i), 32'(line_now()), 32'(exp_q[i]));
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_idle%0d", tag, i), 32'(idle_now()), {21'd0, 3'b001, 8'hBC});
    end
  endtask

  initial begin
    logic [PW-1:0] p;
    logic [7:0]    ln;
    int            gap;

    reset     = 1'b1;
    rsp_valid = 1'b0;
    present(8'h00, 16'h0000, 8'h00, '0, 1'b0);

    // Reset held three cycles, then released
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_line%0d", i), 32'(line_now()), {20'd0, 4'b0001, 8'hBC});
      check($sformatf("rst_clamp%0d", i), 32'(len_clamped), 32'd0);
    end
    reset = 1'b0;
    tick();
    check("rel_ready", 32'(rsp_ready), 32'd1);
    check("rel_line", 32'(idle_now()), {21'd0, 3'b001, 8'hBC});

    // Zero-length frame against literal bytes
    send_start(8'h81, 16'h0001, 8'd0, '0, 1'b0, "len0");
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      check($sformatf("len0_lit%0d", i), 32'(line_now()),
            32'({1'b0, 1'b1, (i == 10), (i == 0 || i >= 7), lit[i]}));
    end
    check_idle("len0", GAP);

    // Full payload containing K-character values
    p = {$urandom, $urandom, $urandom, $urandom};
    p[PW-1 -: 8]        = 8'hFB;
    p[PW-1-8*5 -: 8]    = 8'hBC;
    p[PW-1-8*9 -: 8]    = 8'hFB;
    p[PW-1-8*15 -: 8]   = 8'hFD;
    send_start(8'h42, 16'hBCFD, 8'd16, p, 1'b0, "kdata");
    check("kdata_len", 32'(exp_q.size()), 32'd27);
    check_frame("kdata");
    check_idle("kdata", GAP);

    // Oversized length saturates
    p = {$urandom, $urandom, $urandom, $urandom};
    send_start(8'h05, 16'h1234, 8'd40, p, 1'b0, "clamp");
    check("clamp_lenbyte", 32'(exp_q[4][7:0]), 32'h10);
    check_frame("clamp");
    check_idle("clamp", GAP);

    // Randomized requests, some oversized
    for (int r = 0; r < 8; r++) begin
      ln = 8'($urandom_range(0, 24));
      p  = {$urandom, $urandom, $urandom, $urandom};
      send_start(8'($urandom), 16'($urandom), ln, p, 1'b0, $sformatf("rnd%0d", r));
      check_frame($sformatf("rnd%0d", r));
      check_idle($sformatf("rnd%0d", r), GAP);
    end

    // Back-to-back with rsp_valid held high
    p = {$urandom, $urandom, $urandom, $urandom};
    build_frame(8'hA1, 16'h0A0B, 8'd3, p, 1'b0);
    present(8'hA1, 16'h0A0B, 8'd3, p, 1'b0);
    rsp_valid = 1'b1;
    accept_wait("b2b_a");
    p = {$urandom, $urandom, $urandom, $urandom};
    present(8'hB2, 16'hC0DE, 8'd5, p, 1'b0);
    tick();
    check_frame("b2b_a");
    gap = 0;
    while (gap < 40) begin
      tick();
      if (tx_k_out === 1'b1 && line_out === 8'hFB) break;
      gap++;
    end
    check("b2b_gap", 32'(gap), 32'(GAP + 1));
    rsp_valid = 1'b0;
    build_frame(8'hB2, 16'hC0DE, 8'd5, p, 1'b0);
    scramble();
    check_frame("b2b_b");
    check_idle("b2b_b", GAP);

    // Reset while the third payload byte is on the line
    p = {$urandom, $urandom, $urandom, $urandom};
    send_start(8'h77, 16'h5555, 8'd8, p, 1'b0, "rstmid");
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check($sformatf("rstmid_byte%0d", i), 32'(line_now()), 32'(exp_q[i]));
    end
    reset = 1'b1;
    tick();
    check("rstmid_abort", 32'(line_now()), {20'd0, 4'b0001, 8'hBC});
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rstmid_after%0d", i), 32'(idle_now()), {21'd0, 3'b001, 8'hBC});
    end
    check("rstmid_ready", 32'(rsp_ready), 32'd1);

`ifdef PEDDA_RSP_CRC_ERR_INJECT_EN
    // Corrupted CRC[0], then a clean frame
    send_start(8'h81, 16'h0001, 8'd0, '0, 1'b1, "crcerr");
    check("crcerr_model_l", 32'(exp_q[6][7:0]), 32'h7C);
    check_frame("crcerr");
    check_idle("crcerr", GAP);
    send_start(8'h81, 16'h0001, 8'd0, '0, 1'b0, "crcok");
    check("crcok_model_l", 32'(exp_q[6][7:0]), 32'h7D);
    check_frame("crcok");
    check_idle("crcok", GAP);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
